misr_periph_router: RTL and testbench



---
 rtl/misr_periph_pkg.sv | 14 +
 rtl/misr_addr_map.sv | 35 +++
 rtl/misr_periph_router.sv | 173 +++++++++++++++++
 tb/tb_misr_periph_router.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/misr_periph_pkg.sv
// misr_periph_pkg: shared types and constants for the MISR peripheral router.
package misr_periph_pkg;

   typedef enum logic [1:0] {TGT_SRAM, TGT_MISR, TGT_ERR} target_e;

   typedef enum logic [1:0] {IDLE, SRAM_WAIT, MISR_ACC, RESP} state_e;

   localparam int ERR_CNT_W = 16;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/misr_addr_map.sv
// misr_addr_map: combinational decode of a request into SRAM, MISR channel or error.
module misr_addr_map
   import misr_periph_pkg::*;
#(
   parameter int              NBIT_MISR_DATA         = 32,
   parameter int              NBIT_AXI_WIDTH         = 64,
   parameter int              N_MISR                 = 4,
   parameter longint unsigned MISR_PERIPH_START_ADDR = 64'd33554432,
   parameter int              MISR_STRIDE            = 16,
   localparam int             IDX_W                  = idx_w(N_MISR)
) (
   input  logic [NBIT_AXI_WIDTH-1:0]   addr_i,
   input  logic                        we_i,
   input  logic [NBIT_MISR_DATA/8-1:0] be_i,
   output target_e                     target_o,
   output logic [IDX_W-1:0]            idx_o
);

   localparam logic [NBIT_AXI_WIDTH-1:0] BASE = NBIT_AXI_WIDTH'(MISR_PERIPH_START_ADDR);
   localparam int SH = $clog2(MISR_STRIDE);

   logic [NBIT_AXI_WIDTH-1:0] off;
   logic [NBIT_AXI_WIDTH-1:0] idx_full;
   logic                      in_win;
   logic                      partial;

   assign off      = addr_i - BASE;
   assign idx_full = off >> SH;
   assign in_win   = (idx_full < NBIT_AXI_WIDTH'(N_MISR)) && (off[SH-1:0] == '0);
   // MISR registers cannot merge bytes, so any partial write is rejected
   assign partial  = we_i && (be_i != '1);
   assign target_o = (addr_i < BASE) ? TGT_SRAM : (in_win && !partial) ? TGT_MISR : TGT_ERR;
   assign idx_o    = idx_full[IDX_W-1:0];

endmodule

// File: rtl/misr_periph_router.sv
// misr_periph_router: routes core memory requests to SRAM or MISR channels,
// answering each accepted request once and counting decode errors.
module misr_periph_router
   import misr_periph_pkg::*;
#(
   parameter int              NBIT_MISR_DATA         = 32,
   parameter int              NBIT_AXI_WIDTH         = 64,
   parameter int              USER_AXI_WIDTH         = 10,
   parameter int              N_MISR                 = 4,
   parameter longint unsigned MISR_PERIPH_START_ADDR = 64'd33554432,
   parameter int              MISR_STRIDE            = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               req_i,
   input  logic                               we_i,
   input  logic [NBIT_AXI_WIDTH/8-1:0]        be_i,
   input  logic [NBIT_AXI_WIDTH-1:0]          addr_i,
   input  logic [NBIT_AXI_WIDTH-1:0]          wdata_i,
   input  logic [USER_AXI_WIDTH-1:0]          user_i,
   output logic                               gnt_o,
   output logic                               rvalid_o,
   output logic [NBIT_AXI_WIDTH-1:0]          rdata_o,
   output logic [USER_AXI_WIDTH-1:0]          ruser_o,
   output logic                               err_o,
   output logic                               sram_req_o,
   output logic                               sram_we_o,
   output logic [NBIT_AXI_WIDTH/8-1:0]        sram_be_o,
   output logic [NBIT_AXI_WIDTH-1:0]          sram_addr_o,
   output logic [NBIT_AXI_WIDTH-1:0]          sram_wdata_o,
   output logic [USER_AXI_WIDTH-1:0]          sram_user_o,
   input  logic                               sram_gnt_i,
   input  logic                               sram_rvalid_i,
   input  logic [NBIT_AXI_WIDTH-1:0]          sram_rdata_i,
   output logic [N_MISR-1:0]                  misr_re_o,
   output logic [N_MISR-1:0]                  misr_we_o,
   output logic [NBIT_MISR_DATA-1:0]          misr_wdata_o,
   input  logic [N_MISR*NBIT_MISR_DATA-1:0]   misr_rdata_i,
   output logic [ERR_CNT_W-1:0]               err_cnt_o
);

   localparam int IDX_W = idx_w(N_MISR);

   target_e                   tgt;
   logic [IDX_W-1:0]          idx;
   logic [NBIT_MISR_DATA-1:0] ch_rdata [N_MISR];

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      we_q, we_d;
   logic                      err_q, err_d;
   logic [NBIT_MISR_DATA-1:0] wdata_q, wdata_d;
   logic [NBIT_MISR_DATA-1:0] rdata_q, rdata_d;
   logic [USER_AXI_WIDTH-1:0] user_q, user_d;
   logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;

   misr_addr_map #(
      .NBIT_MISR_DATA         (NBIT_MISR_DATA),
      .NBIT_AXI_WIDTH         (NBIT_AXI_WIDTH),
      .N_MISR                 (N_MISR),
      .MISR_PERIPH_START_ADDR (MISR_PERIPH_START_ADDR),
      .MISR_STRIDE            (MISR_STRIDE)
   ) u_map (
      .addr_i   (addr_i),
      .we_i     (we_i),
      .be_i     (be_i[NBIT_MISR_DATA/8-1:0]),
      .target_o (tgt),
      .idx_o    (idx)
   );

   for (genvar g = 0; g < N_MISR; g++) begin : g_ch
      assign ch_rdata[g] = misr_rdata_i[g*NBIT_MISR_DATA +: NBIT_MISR_DATA];
   end

   assign err_cnt_o = err_cnt_q;
   assign err_cnt_d = (state_q == RESP && err_q && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      we_d         = we_q;
      err_d        = err_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      user_d       = user_q;
      gnt_o        = 1'b0;
      rvalid_o     = 1'b0;
      rdata_o      = '0;
      ruser_o      = '0;
      err_o        = 1'b0;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_be_o    = '0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_user_o  = '0;
      misr_re_o    = '0;
      misr_we_o    = '0;
      misr_wdata_o = '0;
      case (state_q)
         IDLE: begin
            if (tgt == TGT_SRAM) begin
               sram_req_o   = req_i;
               sram_we_o    = req_i & we_i;
               sram_be_o    = req_i ? be_i : '0;
               sram_addr_o  = req_i ? addr_i : '0;
               sram_wdata_o = req_i ? wdata_i : '0;
               sram_user_o  = req_i ? user_i : '0;
               gnt_o        = req_i & sram_gnt_i;
               if (req_i && sram_gnt_i) begin
                  state_d = SRAM_WAIT;
                  user_d  = user_i;
                  err_d   = 1'b0;
               end
            end else begin
               gnt_o = req_i;
               if (req_i) begin
                  idx_d   = idx;
                  we_d    = we_i;
                  wdata_d = wdata_i[NBIT_MISR_DATA-1:0];
                  user_d  = user_i;
                  err_d   = (tgt == TGT_ERR);
                  rdata_d = '0;
                  state_d = (tgt == TGT_ERR) ? RESP : MISR_ACC;
               end
            end
         end
         SRAM_WAIT: begin
            rvalid_o = sram_rvalid_i;
            rdata_o  = sram_rdata_i;
            ruser_o  = user_q;
            state_d  = sram_rvalid_i ? IDLE : SRAM_WAIT;
         end
         MISR_ACC: begin
            misr_re_o[idx_q] = ~we_q;
            misr_we_o[idx_q] = we_q;
            misr_wdata_o     = wdata_q;
            rdata_d          = we_q ? '0 : ch_rdata[idx_q];
            state_d          = RESP;
         end
         RESP: begin
            rvalid_o = 1'b1;
            rdata_o  = NBIT_AXI_WIDTH'(rdata_q);
            ruser_o  = user_q;
            err_o    = err_q;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         user_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         user_q    <= user_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_misr_periph_router.sv
// tb_misr_periph_router: directed checks of decode, latency, errors, saturation and reset.
module tb_misr_periph_router;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         req, we;
   logic [7:0]   be;
   logic [63:0]  addr, wdata;
   logic [9:0]   user;
   logic         gnt, rvalid, err;
   logic [63:0]  rdata;
   logic [9:0]   ruser;
   logic         sram_req, sram_we;
   logic [7:0]   sram_be;
   logic [63:0]  sram_addr, sram_wdata;
   logic [9:0]   sram_user;
   logic         sram_gnt, sram_rvalid;
   logic [63:0]  sram_rdata;
   logic [3:0]   misr_re, misr_we;
   logic [31:0]  misr_wdata;
   logic [127:0] misr_rdata;
   logic [15:0]  err_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   misr_periph_router dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .we_i          (we),
      .be_i          (be),
      .addr_i        (addr),
      .wdata_i       (wdata),
      .user_i        (user),
      .gnt_o         (gnt),
      .rvalid_o      (rvalid),
      .rdata_o       (rdata),
      .ruser_o       (ruser),
      .err_o         (err),
      .sram_req_o    (sram_req),
      .sram_we_o     (sram_we),
      .sram_be_o     (sram_be),
      .sram_addr_o   (sram_addr),
      .sram_wdata_o  (sram_wdata),
      .sram_user_o   (sram_user),
      .sram_gnt_i    (sram_gnt),
      .sram_rvalid_i (sram_rvalid),
      .sram_rdata_i  (sram_rdata),
      .misr_re_o     (misr_re),
      .misr_we_o     (misr_we),
      .misr_wdata_o  (misr_wdata),
      .misr_rdata_i  (misr_rdata),
      .err_cnt_o     (err_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // inputs change at the falling edge; outputs are sampled 1 time unit later
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic err_req(input logic [63:0] a, input logic w, input logic [7:0] b,
                          input logic [15:0] cnt_before, input logic [15:0] cnt_after);
      cyc(); req = 1'b1; addr = a; we = w; be = b; wdata = 64'hFFFF_FFFF_FFFF_FFFF; settle();
      check("err_gnt", gnt, 1);
      cyc(); req = 1'b0; settle();
      check("err_rvalid", rvalid, 1);
      check("err_flag", err, 1);
      check("err_rdata", rdata, 0);
      check("err_strobes", {misr_re, misr_we}, 0);
      check("err_cnt_hold", err_cnt, cnt_before);
      cyc(); settle();
      check("err_rvalid_off", rvalid, 0);
      check("err_cnt", err_cnt, cnt_after);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; user = '0;
      sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = '0;
      misr_rdata = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
      repeat (2) cyc();
      settle();
      check("rst_rvalid", rvalid, 0);
      check("rst_gnt", gnt, 0);
      check("rst_sram_req", sram_req, 0);
      check("rst_strobes", {misr_re, misr_we}, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_rdata", rdata, 0);
      cyc(); rst = 1'b0;

      // MISR read channel 2
      cyc(); req = 1'b1; we = 1'b0; be = 8'h00; addr = BASE + 64'd32; user = 10'h155; settle();
      check("rd_gnt", gnt, 1);
      check("rd_no_sram", sram_req, 0);
      cyc(); req = 1'b0; settle();
      check("rd_re", misr_re, 4'b0100);
      check("rd_we", misr_we, 0);
      check("rd_rvalid_c1", rvalid, 0);
      cyc(); settle();
      check("rd_rvalid", rvalid, 1);
      check("rd_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
      check("rd_err", err, 0);
      check("rd_ruser", ruser, 10'h155);
      cyc(); settle();
      check("rd_done", rvalid, 0);

      // MISR write channel 3
      cyc(); req = 1'b1; we = 1'b1; be = 8'h0F; addr = BASE + 64'd48;
      wdata = 64'h1234_5678_CAFE_F00D; user = 10'h0AA; settle();
      check("wr_gnt", gnt, 1);
      cyc(); req = 1'b0; settle();
      check("wr_we", misr_we, 4'b1000);
      check("wr_re", misr_re, 0);
      check("wr_wdata", misr_wdata, 32'hCAFE_F00D);
      cyc(); settle();
      check("wr_rvalid", rvalid, 1);
      check("wr_err", err, 0);
      check("wr_rdata", rdata, 0);

      // decode errors: past last channel, misaligned, partial write
      err_req(BASE + 64'd64, 1'b0, 8'hFF, 16'd0, 16'd1);
      err_req(BASE + 64'd4,  1'b0, 8'hFF, 16'd1, 16'd2);
      err_req(BASE + 64'd16, 1'b1, 8'h03, 16'd2, 16'd3);

      // saturation from a preloaded count
      cyc(); force dut.err_cnt_q = 16'hFFFE;
      cyc(); release dut.err_cnt_q; settle();
      check("sat_preload", err_cnt, 16'hFFFE);
      err_req(BASE + 64'd64, 1'b0, 8'hFF, 16'hFFFE, 16'hFFFF);
      err_req(BASE + 64'd64, 1'b0, 8'hFF, 16'hFFFF, 16'hFFFF);
      err_req(BASE + 64'd64, 1'b0, 8'hFF, 16'hFFFF, 16'hFFFF);

      // SRAM read with stalled grant
      for (int i = 0; i < 3; i++) begin
         cyc(); req = 1'b1; we = 1'b0; be = 8'hFF; addr = 64'h1000; user = 10'h2A5; sram_gnt = 1'b0; settle();
         check("sram_stall_gnt", gnt, 0);
         check("sram_stall_req", sram_req, 1);
         check("sram_stall_addr", sram_addr, 64'h1000);
      end
      cyc(); sram_gnt = 1'b1; settle();
      check("sram_gnt", gnt, 1);
      check("sram_user", sram_user, 10'h2A5);
      cyc(); req = 1'b0; sram_gnt = 1'b0; user = 10'h000; settle();
      check("sram_wait_noreq", sram_req, 0);
      check("sram_wait_rvalid", rvalid, 0);
      cyc(); sram_rvalid = 1'b1; sram_rdata = 64'hA5A5_0000_1111_2222; settle();
      check("sram_rvalid", rvalid, 1);
      check("sram_rdata", rdata, 64'hA5A5_0000_1111_2222);
      check("sram_ruser", ruser, 10'h2A5);
      check("sram_err", err, 0);
      cyc(); sram_rvalid = 1'b0; settle();
      check("sram_done", rvalid, 0);

      // request held through a MISR access
      cyc(); req = 1'b1; we = 1'b0; addr = BASE + 64'd16; user = 10'h011; settle();
      check("hold_gnt0", gnt, 1);
      cyc(); settle();
      check("hold_gnt_acc", gnt, 0);
      cyc(); settle();
      check("hold_gnt_resp", gnt, 0);
      check("hold_rvalid1", rvalid, 1);
      check("hold_rdata1", rdata, 64'h2222_2222);
      cyc(); settle();
      check("hold_gnt_idle", gnt, 1);
      check("hold_no_dup", rvalid, 0);
      cyc(); req = 1'b0; settle();
      check("hold_re", misr_re, 4'b0010);
      cyc(); settle();
      check("hold_rvalid2", rvalid, 1);
      cyc(); settle();
      check("hold_done", rvalid, 0);

      // reset in MISR_ACC drops the response
      cyc(); req = 1'b1; we = 1'b0; addr = BASE + 64'd48; settle();
      check("rstm_gnt", gnt, 1);
      cyc(); req = 1'b0; rst = 1'b1; settle();
      check("rstm_re", misr_re, 4'b1000);
      cyc(); settle();
      check("rstm_rvalid", rvalid, 0);
      check("rstm_strobes", {misr_re, misr_we}, 0);
      check("rstm_cnt", err_cnt, 0);
      check("rstm_rdata", rdata, 0);
      cyc(); rst = 1'b0; settle();
      check("rstm_rvalid2", rvalid, 0);
      cyc(); sram_rvalid = 1'b1; settle();
      check("stray_rvalid", rvalid, 0);
      check("stray_gnt", gnt, 0);
      cyc(); sram_rvalid = 1'b0; settle();
      check("stray_after", rvalid, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
